// File: rtl/memb_stream_reader.sv
// Memory-B read-out engine: reads every location in address order and streams
// each word on a valid/ready interface with sign/last tags and a running sum.
module memb_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          RdEnB,
  output logic [DEPTH_LOG2-1:0]         RdAddrB,
  input  logic [WIDTH-1:0]              DOutB,
  output logic [WIDTH-1:0]              DataOut,
  output logic                          DataValid,
  input  logic                          DataReady,
  output logic                          Sign,
  output logic                          Last,
  output logic                          Busy,
  output logic                          Done,
  output logic [WIDTH+DEPTH_LOG2-1:0]   Sum
);

  localparam int SUM_W = WIDTH + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic                    at_last;
  logic [SUM_W-1:0]        data_ext;

  assign at_last  = (cnt_q == LAST_ADDR);
  assign data_ext = {{DEPTH_LOG2{data_q[WIDTH-1]}}, data_q};

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sum_d   = sum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        data_d  = DOutB;
        state_d = S_SEND;
      end
      S_SEND: begin
        // The word is held until the consumer takes it; no new read meanwhile.
        if (DataReady) begin
          sum_d = sum_q + data_ext;
          if (at_last) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign RdEnB     = (state_q == S_ISSUE);
  assign RdAddrB   = cnt_q;
  assign DataOut   = data_q;
  assign DataValid = (state_q == S_SEND);
  assign Sign      = data_q[WIDTH-1];
  assign Last      = (state_q == S_SEND) && at_last;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Sum       = sum_q;

endmodule

// File: tb/tb_memb_stream_reader.sv
// Scoreboard bench for memb_stream_reader: directed read-outs push expected
// words, a negedge monitor pops and compares on every transfer.
module tb_memb_stream_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       RdEnB;
  logic [1:0] RdAddrB;
  logic [7:0] DOutB;
  logic [7:0] DataOut;
  logic       DataValid;
  logic       DataReady;
  logic       Sign;
  logic       Last;
  logic       Busy;
  logic       Done;
  logic [9:0] Sum;

  memb_stream_reader #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .RdEnB(RdEnB), .RdAddrB(RdAddrB), .DOutB(DOutB),
    .DataOut(DataOut), .DataValid(DataValid), .DataReady(DataReady),
    .Sign(Sign), .Last(Last), .Busy(Busy), .Done(Done), .Sum(Sum)
  );

  always #5 clk = ~clk;

  // Memory B with a registered read port.
  logic [7:0] mem [4];
  always @(posedge clk) if (RdEnB) DOutB <= mem[RdAddrB];

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   xfers = 0;
  int   done_seen = 0;
  int   cyc = 0;

  // Ready driver: default level, optionally low for stall_left SEND cycles of word stall_word.
  logic ready_default = 1'b1;
  int   stall_word = -1;
  int   stall_left = 0;
  int   xfer_base = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    if (DataValid && stall_left > 0 && (xfers - xfer_base) == stall_word) begin
      DataReady = 1'b0;
      stall_left--;
    end else begin
      DataReady = ready_default;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (DataValid && DataReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected no transfer (t=%0t)", DataOut, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data", DataOut, e.data);
          check("sign", Sign, e.data[7]);
          check("last", Last, e.last);
        end
        xfers++;
      end else if (DataValid) begin
        if (exp_q.size() > 0) check("hold_data", DataOut, exp_q[0].data);
        check("hold_no_rden", RdEnB, 1'b0);
      end
      if (Done) done_seen++;
    end
  end

  task automatic load_mem(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic push_words();
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.data = mem[i];
      e.last = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rden"}, RdEnB, 1'b0);
    check({tag, "_addr"}, RdAddrB, 2'd0);
    check({tag, "_data"}, DataOut, 8'd0);
    check({tag, "_valid"}, DataValid, 1'b0);
    check({tag, "_sign"}, Sign, 1'b0);
    check({tag, "_last"}, Last, 1'b0);
    check({tag, "_busy"}, Busy, 1'b0);
    check({tag, "_done"}, Done, 1'b0);
    check({tag, "_sum"}, Sum, 10'd0);
  endtask

  // Pulses start for one edge (E0); returns at E0+1 with the ISSUE cycle visible.
  task automatic do_start();
    xfer_base = xfers;
    push_words();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_rden", RdEnB, 1'b1);
    check("start_addr0", RdAddrB, 2'd0);
    check("start_sum_clear", Sum, 10'd0);
  endtask

  // Counts cycles from start (already at E0+1) to the Done cycle, then checks Busy falls.
  task automatic wait_done(output int n);
    n = 1;
    while (!Done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!Done) check("done_timeout", 0, 1);
    @(posedge clk); #1;
    check("busy_fall", Busy, 1'b0);
  endtask

  int n;
  int d0, x0;
  int t_first, t_second;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    DataReady = 1'b0;
    load_mem(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    reset = 1'b1;

    // Negative words, ready held high.
    load_mem(8'hFE, 8'hFD, 8'hFC, 8'hF9);
    do_start();
    wait_done(n);
    check("basic_latency", n, 13);
    check("basic_sum", Sum, 10'h3F0);
    check("basic_drained", exp_q.size(), 0);

    // Backpressure: 5 stall cycles on the second word.
    stall_word = 1;
    stall_left = 5;
    do_start();
    wait_done(n);
    check("bp_latency", n, 18);
    check("bp_sum", Sum, 10'h3F0);
    stall_word = -1;

    // Extremes: +127 x4 then -128 x4.
    load_mem(8'h7F, 8'h7F, 8'h7F, 8'h7F);
    do_start();
    wait_done(n);
    check("max_sum", Sum, 10'd508);
    load_mem(8'h80, 8'h80, 8'h80, 8'h80);
    do_start();
    wait_done(n);
    check("min_sum", Sum, 10'h200);

    // Start pulsed during SEND is ignored.
    load_mem(8'h01, 8'h02, 8'h03, 8'h04);
    d0 = done_seen;
    x0 = xfers;
    do_start();
    n = 0;
    while (!DataValid && n < 20) begin @(posedge clk); #1; n++; end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(n);
    repeat (5) @(posedge clk);
    #1;
    check("ign_xfers", xfers - x0, 4);
    check("ign_dones", done_seen - d0, 1);
    check("ign_idle", Busy, 1'b0);
    check("ign_sum", Sum, 10'd10);

    // Reset during CAPTURE of the third word.
    load_mem(8'h11, 8'h22, 8'h33, 8'h44);
    d0 = done_seen;
    do_start();
    n = 0;
    while (!(RdEnB && (xfers - xfer_base) == 2) && n < 50) begin @(posedge clk); #1; n++; end
    check("rst_reach_issue3", RdAddrB, 2'd2);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    reset = 1'b1;
    exp_q.delete();
    repeat (20) @(posedge clk);
    #1 check("midrst_no_done", done_seen - d0, 0);
    do_start();
    wait_done(n);
    check("after_rst_latency", n, 13);
    check("after_rst_sum", Sum, 10'h0AA);

    // Start held high: back-to-back read-outs, 14 cycles apart.
    load_mem(8'hFF, 8'h01, 8'hFF, 8'h02);
    xfer_base = xfers;
    push_words();
    push_words();
    d0 = done_seen;
    @(posedge clk); #1 start = 1'b1;
    n = 0;
    while (!Done && n < 50) begin @(posedge clk); #1; n++; end
    t_first = cyc;
    @(posedge clk); #1;
    n = 0;
    while (!Done && n < 50) begin @(posedge clk); #1; n++; end
    t_second = cyc;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("held_period", t_second - t_first, 14);
    check("held_dones", done_seen - d0, 2);
    check("held_xfers", xfers - xfer_base, 8);
    check("held_idle", Busy, 1'b0);
    check("held_sum", Sum, 10'd1);
    check("held_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
